// File: rtl/serial_add_ctrl.sv
// Start/busy/done sequencer around a 1-bit full adder with a registered carry.
// Operands are shifted LSB-first and the sum is rebuilt in a right-shifting register.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    logic bit_a, bit_b, bit_s, bit_c;

    // The adder slice itself: one full-adder step on the current LSBs.
    assign bit_a = a_sr_q[0];
    assign bit_b = b_sr_q[0];
    assign bit_s = bit_a ^ bit_b ^ carry_q;
    assign bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
                carry_d  = bit_c;
                count_d  = count_q + 1'b1;
                // Results are published only here, so sum/cout stay put during the next add.
                if (count_q == LAST_BIT) begin
                    sum_d   = sum_sr_d;
                    cout_d  = bit_c;
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            count_q  <= count_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, using an
// arithmetic reference ({cout,sum} = a+b+cin) and fixed-latency handshake expectations.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic       a1, b1, sum1;

    int n_total = 0;
    int n_bad   = 0;
    logic [8:0] last_res [2];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input int w);
        return (w == 8) ? 0 : 1;
    endfunction

    // Reference: plain integer addition of the operands truncated to w bits.
    function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
        int m;
        m = (1 << w) - 1;
        return 9'((int'(a) & m) + (int'(b) & m) + int'(c));
    endfunction

    task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s);
        if (w == 8) begin
            a8 = a; b8 = b; cin8 = c; start8 = s;
        end else begin
            a1 = a[0]; b1 = b[0]; cin1 = c; start1 = s;
        end
    endtask

    task automatic sample(input int w, output logic bz, output logic dn, output logic [8:0] res);
        if (w == 8) begin
            bz = busy8; dn = done8; res = {cout8, sum8};
        end else begin
            bz = busy1; dn = done1; res = {7'd0, cout1, sum1};
        end
    endtask

    // Launch from IDLE or DONE, then walk the w SHIFT cycles; operands are scrambled
    // (and start optionally held) throughout to prove they are not re-sampled.
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit hold, input string tag);
        logic [8:0] exp, res;
        logic       bz, dn;
        int         k;
        k   = idx_of(w);
        exp = model(w, a, b, c);
        drive(w, a, b, c, 1'b1);
        tick();
        for (int i = 0; i < w; i++) begin
            sample(w, bz, dn, res);
            check({tag, ".busy"}, 64'(bz), 64'd1);
            check({tag, ".nodone"}, 64'(dn), 64'd0);
            check({tag, ".held"}, 64'(res), 64'(last_res[k]));
            drive(w, 8'($urandom), 8'($urandom), 1'($urandom), hold);
            tick();
        end
        sample(w, bz, dn, res);
        check({tag, ".done"}, 64'(dn), 64'd1);
        check({tag, ".busy_lo"}, 64'(bz), 64'd0);
        check({tag, ".result"}, 64'(res), 64'(exp));
        last_res[k] = exp;
    endtask

    task automatic idle(input int w, input int n, input string tag);
        logic [8:0] res;
        logic       bz, dn;
        int         k;
        k = idx_of(w);
        drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < n; i++) begin
            tick();
            sample(w, bz, dn, res);
            check({tag, ".idle_busy"}, 64'(bz), 64'd0);
            check({tag, ".idle_done"}, 64'(dn), 64'd0);
            check({tag, ".idle_hold"}, 64'(res), 64'(last_res[k]));
        end
    endtask

    initial begin
        logic [8:0] res;
        logic       bz, dn;

        reset_n = 1'b0;
        drive(8, 8'd0, 8'd0, 1'b0, 1'b0);
        drive(1, 8'd0, 8'd0, 1'b0, 1'b0);
        last_res[0] = '0;
        last_res[1] = '0;
        #2;
        sample(8, bz, dn, res);
        check("rst8.busy", 64'(bz), 64'd0);
        check("rst8.done", 64'(dn), 64'd0);
        check("rst8.res", 64'(res), 64'd0);
        sample(1, bz, dn, res);
        check("rst1.busy", 64'(bz), 64'd0);
        check("rst1.res", 64'(res), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        idle(8, 2, "post_rst");

        do_op(8, 8'h5A, 8'h3C, 1'b0, 1'b0, "basic");
        idle(8, 1, "basic");
        do_op(8, 8'hFF, 8'h01, 1'b0, 1'b0, "carry_ab");
        idle(8, 1, "carry_ab");
        do_op(8, 8'hFF, 8'h00, 1'b1, 1'b0, "carry_cin");
        idle(8, 1, "carry_cin");

        // start held high across SHIFT; the next op may only start in the DONE cycle
        do_op(8, 8'h12, 8'h34, 1'b1, 1'b1, "hold");
        do_op(8, 8'h40, 8'h22, 1'b0, 1'b0, "hold_next");
        // start in the DONE cycle: second done lands exactly WIDTH+1 cycles later
        do_op(8, 8'h01, 8'h01, 1'b0, 1'b0, "b2b");
        idle(8, 2, "b2b");

        // asynchronous reset in the middle of an add
        drive(8, 8'hA5, 8'h5A, 1'b1, 1'b1);
        tick();
        drive(8, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        sample(8, bz, dn, res);
        check("mid.busy", 64'(bz), 64'd1);
        reset_n = 1'b0;
        #1;
        sample(8, bz, dn, res);
        check("arst.busy", 64'(bz), 64'd0);
        check("arst.done", 64'(dn), 64'd0);
        check("arst.res", 64'(res), 64'd0);
        last_res[0] = '0;
        last_res[1] = '0;
        tick();
        tick();
        reset_n = 1'b1;
        idle(8, 10, "arst_quiet");
        do_op(8, 8'h10, 8'h20, 1'b0, 1'b0, "after_rst");
        idle(8, 1, "after_rst");

        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 8 : 1;
            for (int n = 0; n < 1000; n++) begin
                do_op(w, 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)),
                      (w == 8) ? "rnd8" : "rnd1");
                if ($urandom_range(0, 2) != 0)
                    idle(w, $urandom_range(1, 3), (w == 8) ? "rnd8" : "rnd1");
            end
            idle(w, 1, "rnd_end");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
